idec_stage: RTL and testbench

//  Registered, parametrised instruction-decode pipeline stage between fetch and execute.

---
 rtl/idec_stage_pkg.sv | 74 +++++++
 rtl/idec_stage_field_decode.sv | 104 ++++++++++
 rtl/idec_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_idec_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idec_stage_pkg.sv
// -----------------------------------------------------------------------------
// idec_stage_pkg
// Shared constants, op-type encoding and helper functions for the instruction
// decode stage (idec_stage) and its field decoder (idec_field_decode).
//   FULLW / REGAW / ALUAW / FLAGSW : default datapath, register, ALU, flag widths
//   SHIFTCODEW                     : width of the shift-type code
//   OP_TYPE_W, op_type_e           : instruction class derived from instr[27:25]
//   ROR                            : shift-type code for rotate-right
//   COND_AL                        : "always" condition code
//   condchecker()                  : ARM condition evaluation against NZCV
//   op_type_of()                   : instruction class lookup
// -----------------------------------------------------------------------------
package idec_stage_pkg;

  localparam int FULLW      = 32;
  localparam int REGAW      = 4;
  localparam int ALUAW      = 4;
  localparam int FLAGSW     = 4;
  localparam int SHIFTCODEW = 2;
  localparam int OP_TYPE_W  = 3;

  typedef enum logic [OP_TYPE_W-1:0] {
    OP_DATA_SHIFT = 3'd0,
    OP_DATA_ROR   = 3'd1,
    OP_LDSTR      = 3'd2,
    OP_BRANCH     = 3'd3,
    OP_OTHER      = 3'd4
  } op_type_e;

  localparam logic [SHIFTCODEW-1:0] ROR     = 2'b11;
  localparam logic [3:0]            COND_AL = 4'hE;

  // Condition code evaluation; flags are packed as {N,Z,C,V}. 4'hF never passes.
  function automatic logic condchecker(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'h0:    ok = z;
      4'h1:    ok = ~z;
      4'h2:    ok = c;
      4'h3:    ok = ~c;
      4'h4:    ok = n;
      4'h5:    ok = ~n;
      4'h6:    ok = v;
      4'h7:    ok = ~v;
      4'h8:    ok = c & ~z;
      4'h9:    ok = ~c | z;
      4'hA:    ok = (n == v);
      4'hB:    ok = (n != v);
      4'hC:    ok = ~z & (n == v);
      4'hD:    ok = z | (n != v);
      4'hE:    ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Instruction class from the major opcode bits instr[27:25].
  function automatic op_type_e op_type_of(input logic [2:0] cls);
    op_type_e t;
    case (cls)
      3'b000:         t = OP_DATA_SHIFT;
      3'b001:         t = OP_DATA_ROR;
      3'b010, 3'b011: t = OP_LDSTR;
      3'b101:         t = OP_BRANCH;
      default:        t = OP_OTHER;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/idec_stage_field_decode.sv
// -----------------------------------------------------------------------------
// idec_field_decode
// Pure combinational decoder: instruction word + committed flags -> decoded
// fields and drop qualifiers. No state.
//   instr      in   DATA_W   instruction word
//   cpsr       in   FLAGS_W  committed NZCV flags
//   op_type    out           instruction class
//   alu, rn, rd, rm, cpsrs, reg_we, mem_we, ib, bl, should_bypass_rm,
//   bv, bypass_rm, shiftcode, shiftby   out   decoded fields (0 when unused)
//   cond_pass  out  1        condition code passes against cpsr
//   is_cond    out  1        condition code is not AL
//   is_sop     out  1        data op that will write the flags
//   drop       out  1        structurally undecodable (zero word or unknown class)
// -----------------------------------------------------------------------------
module idec_field_decode
  import idec_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter int ALU_AW  = 4,
  parameter int FLAGS_W = 4,
  parameter int SHIFT_W = 8
) (
  input  logic [DATA_W-1:0]     instr,
  input  logic [FLAGS_W-1:0]    cpsr,
  output op_type_e              op_type,
  output logic [ALU_AW-1:0]     alu,
  output logic [REG_AW-1:0]     rn,
  output logic [REG_AW-1:0]     rd,
  output logic [REG_AW-1:0]     rm,
  output logic                  cpsrs,
  output logic                  reg_we,
  output logic                  mem_we,
  output logic                  ib,
  output logic                  bl,
  output logic                  should_bypass_rm,
  output logic [DATA_W-1:0]     bv,
  output logic [DATA_W-1:0]     bypass_rm,
  output logic [SHIFTCODEW-1:0] shiftcode,
  output logic [SHIFT_W-1:0]    shiftby,
  output logic                  cond_pass,
  output logic                  is_cond,
  output logic                  is_sop,
  output logic                  drop
);

  // Field extraction per instruction class; unused fields stay zero.
  always_comb begin
    op_type          = op_type_of(instr[27:25]);
    alu              = '0;
    rn               = '0;
    rd               = '0;
    rm               = '0;
    cpsrs            = 1'b0;
    reg_we           = 1'b0;
    mem_we           = 1'b0;
    ib               = 1'b0;
    bl               = 1'b0;
    should_bypass_rm = 1'b0;
    bv               = '0;
    bypass_rm        = '0;
    shiftcode        = '0;
    shiftby          = '0;
    cond_pass        = condchecker(instr[31:28], cpsr[3:0]);
    is_cond          = (instr[31:28] != COND_AL);
    case (op_type)
      OP_DATA_SHIFT, OP_DATA_ROR: begin
        alu    = ALU_AW'(instr[24:21]);
        rn     = REG_AW'(instr[19:16]);
        rd     = REG_AW'(instr[15:12]);
        rm     = REG_AW'(instr[3:0]);
        cpsrs  = instr[20];
        reg_we = 1'b1;
        if (op_type == OP_DATA_ROR) begin
          // Immediate form: 8-bit value rotated by twice the 4-bit rotate field.
          should_bypass_rm = 1'b1;
          shiftcode        = ROR;
          shiftby          = SHIFT_W'({instr[11:8], 1'b0});
          bypass_rm        = DATA_W'(instr[7:0]);
        end else begin
          should_bypass_rm = 1'b0;
        end
      end
      OP_LDSTR: begin
        rn     = REG_AW'(instr[19:16]);
        rd     = REG_AW'(instr[15:12]);
        reg_we = instr[20];
        mem_we = ~instr[20];
      end
      OP_BRANCH: begin
        ib = 1'b1;
        bl = instr[24];
        // Word offset: sign-extend the 24-bit field and scale by 4.
        bv = {{(DATA_W-26){instr[23]}}, instr[23:0], 2'b00};
      end
      default: begin
        cpsrs = 1'b0;
      end
    endcase
    is_sop = ((op_type == OP_DATA_SHIFT) | (op_type == OP_DATA_ROR)) & instr[20];
    drop   = (instr == '0) | (op_type == OP_OTHER);
  end

endmodule

// File: rtl/idec_stage.sv
// -----------------------------------------------------------------------------
// idec_stage
// Registered instruction-decode stage between fetch and execute. Owns the
// valid/ready handshake, the branch-shadow squash counter and the count of
// flag-setting ops still in flight; field decoding lives in idec_field_decode.
//   clk, rst (async, active-high)
//   in_valid / in_ready / instr_in     fetch side handshake and instruction
//   cpsr_in                            committed NZCV flags
//   flags_wb                           one flag-setter retired
//   flush                              kill output register and branch shadow
//   out_valid / out_ready              execute side handshake
//   alu_out, rn_out, rd_out, rm_out, cpsrs_out, reg_we, mem_we, ib, bl,
//   should_bypass_rm, bv, bypass_rm, shiftcode, shiftby   registered decode
// Build option IDEC_PERF_EN adds perf_issued / perf_squashed / perf_stalled
// (32-bit wrapping event counters).
// -----------------------------------------------------------------------------
module idec_stage
  import idec_stage_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 4,
  parameter int ALU_AW    = 4,
  parameter int FLAGS_W   = 4,
  parameter int SHIFT_W   = 8,
  parameter int BR_SHADOW = 1,
  parameter int MAX_PEND  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     instr_in,
  input  logic [FLAGS_W-1:0]    cpsr_in,
  input  logic                  flags_wb,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_AW-1:0]     alu_out,
  output logic [REG_AW-1:0]     rn_out,
  output logic [REG_AW-1:0]     rd_out,
  output logic [REG_AW-1:0]     rm_out,
  output logic                  cpsrs_out,
  output logic                  reg_we,
  output logic                  mem_we,
  output logic                  ib,
  output logic                  bl,
  output logic                  should_bypass_rm,
  output logic [DATA_W-1:0]     bv,
  output logic [DATA_W-1:0]     bypass_rm,
  output logic [SHIFTCODEW-1:0] shiftcode,
  output logic [SHIFT_W-1:0]    shiftby
`ifdef IDEC_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_squashed,
  output logic [31:0]           perf_stalled
`endif
);

  localparam logic [2:0] BR_SHADOW_C = 3'(BR_SHADOW);
  localparam logic [2:0] MAX_PEND_C  = 3'(MAX_PEND);

  op_type_e                fd_op_type_s;
  logic [ALU_AW-1:0]       fd_alu_s;
  logic [REG_AW-1:0]       fd_rn_s, fd_rd_s, fd_rm_s;
  logic                    fd_cpsrs_s, fd_reg_we_s, fd_mem_we_s, fd_ib_s, fd_bl_s, fd_sbr_s;
  logic [DATA_W-1:0]       fd_bv_s, fd_bypass_rm_s;
  logic [SHIFTCODEW-1:0]   fd_shiftcode_s;
  logic [SHIFT_W-1:0]      fd_shiftby_s;
  logic                    fd_cond_pass_s, fd_is_cond_s, fd_is_sop_s, fd_drop_s;

  logic [2:0] shadow_cnt_r;
  logic [2:0] pend_cnt_r;
  logic       pending_s, stall_s, accept_s, handshake_s, issue_s, squash_s;
  logic       pend_inc_s, pend_dec_s;

  idec_field_decode #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .ALU_AW (ALU_AW),
    .FLAGS_W(FLAGS_W),
    .SHIFT_W(SHIFT_W)
  ) u_field_decode (
    .instr           (instr_in),
    .cpsr            (cpsr_in),
    .op_type         (fd_op_type_s),
    .alu             (fd_alu_s),
    .rn              (fd_rn_s),
    .rd              (fd_rd_s),
    .rm              (fd_rm_s),
    .cpsrs           (fd_cpsrs_s),
    .reg_we          (fd_reg_we_s),
    .mem_we          (fd_mem_we_s),
    .ib              (fd_ib_s),
    .bl              (fd_bl_s),
    .should_bypass_rm(fd_sbr_s),
    .bv              (fd_bv_s),
    .bypass_rm       (fd_bypass_rm_s),
    .shiftcode       (fd_shiftcode_s),
    .shiftby         (fd_shiftby_s),
    .cond_pass       (fd_cond_pass_s),
    .is_cond         (fd_is_cond_s),
    .is_sop          (fd_is_sop_s),
    .drop            (fd_drop_s)
  );

  // Handshake, hazard stall and issue/squash qualification.
  always_comb begin
    // A flag-setter sitting in our own output register counts as unresolved.
    pending_s   = (pend_cnt_r != 3'd0) | (out_valid & cpsrs_out);
    stall_s     = ~flush & ((fd_is_cond_s & pending_s) |
                            (fd_is_sop_s & (pend_cnt_r == MAX_PEND_C)));
    // Flush also blocks acceptance so fetch never sees a false handshake.
    in_ready    = (~out_valid | out_ready) & ~stall_s & ~flush;
    accept_s    = in_valid & in_ready;
    handshake_s = out_valid & out_ready;
    issue_s     = accept_s & (shadow_cnt_r == 3'd0) & fd_cond_pass_s & ~fd_drop_s;
    squash_s    = accept_s & ~issue_s;
    pend_inc_s  = handshake_s & cpsrs_out;
    pend_dec_s  = flags_wb & (pend_cnt_r != 3'd0);
  end

  // Output register: load on issue, clear on drain/drop/flush, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      alu_out          <= '0;
      rn_out           <= '0;
      rd_out           <= '0;
      rm_out           <= '0;
      cpsrs_out        <= 1'b0;
      reg_we           <= 1'b0;
      mem_we           <= 1'b0;
      ib               <= 1'b0;
      bl               <= 1'b0;
      should_bypass_rm <= 1'b0;
      bv               <= '0;
      bypass_rm        <= '0;
      shiftcode        <= '0;
      shiftby          <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_s) begin
      out_valid <= issue_s;
      if (issue_s) begin
        alu_out          <= fd_alu_s;
        rn_out           <= fd_rn_s;
        rd_out           <= fd_rd_s;
        rm_out           <= fd_rm_s;
        cpsrs_out        <= fd_cpsrs_s;
        reg_we           <= fd_reg_we_s;
        mem_we           <= fd_mem_we_s;
        ib               <= fd_ib_s;
        bl               <= fd_bl_s;
        should_bypass_rm <= fd_sbr_s;
        bv               <= fd_bv_s;
        bypass_rm        <= fd_bypass_rm_s;
        shiftcode        <= fd_shiftcode_s;
        shiftby          <= fd_shiftby_s;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Branch shadow: each accepted instruction while non-zero is squashed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_cnt_r <= 3'd0;
    end else if (flush) begin
      shadow_cnt_r <= 3'd0;
    end else if (accept_s && (shadow_cnt_r != 3'd0)) begin
      shadow_cnt_r <= shadow_cnt_r - 3'd1;
    end else if (issue_s && (fd_op_type_s == OP_BRANCH)) begin
      shadow_cnt_r <= BR_SHADOW_C;
    end
  end

  // Flag-setters past this stage whose flags are not yet committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt_r <= 3'd0;
    end else begin
      case ({pend_inc_s, pend_dec_s})
        2'b10: begin
          if (pend_cnt_r != MAX_PEND_C) begin
            pend_cnt_r <= pend_cnt_r + 3'd1;
          end
        end
        2'b01:   pend_cnt_r <= pend_cnt_r - 3'd1;
        default: pend_cnt_r <= pend_cnt_r;
      endcase
    end
  end

`ifdef IDEC_PERF_EN
  // Wrapping event counters for issue, squash and stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued   <= 32'd0;
      perf_squashed <= 32'd0;
      perf_stalled  <= 32'd0;
    end else begin
      if (handshake_s) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if (squash_s) begin
        perf_squashed <= perf_squashed + 32'd1;
      end
      if (in_valid && stall_s) begin
        perf_stalled <= perf_stalled + 32'd1;
      end
    end
  end
`else
  logic unused_squash_s;
  assign unused_squash_s = squash_s;
`endif

endmodule

// File: tb/tb_idec_stage.sv
// Self-checking bench for idec_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the decode stage.
module tb_idec_stage;

  localparam int          BRS    = 1;
  localparam int          MAXP   = 2;
  localparam logic [1:0]  SC_ROR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flags_wb, flush, out_valid, out_ready;
  logic [31:0] instr_in;
  logic [3:0]  cpsr_in;
  logic [3:0]  alu_out, rn_out, rd_out, rm_out;
  logic        cpsrs_out, reg_we, mem_we, ib, bl, should_bypass_rm;
  logic [31:0] bv, bypass_rm;
  logic [1:0]  shiftcode;
  logic [7:0]  shiftby;
`ifdef IDEC_PERF_EN
  logic [31:0] perf_issued, perf_squashed, perf_stalled;
`endif

  always #5 clk = ~clk;

  idec_stage #(.BR_SHADOW(BRS), .MAX_PEND(MAXP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .cpsr_in(cpsr_in), .flags_wb(flags_wb), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .rn_out(rn_out), .rd_out(rd_out), .rm_out(rm_out), .cpsrs_out(cpsrs_out),
    .reg_we(reg_we), .mem_we(mem_we), .ib(ib), .bl(bl),
    .should_bypass_rm(should_bypass_rm), .bv(bv), .bypass_rm(bypass_rm),
    .shiftcode(shiftcode), .shiftby(shiftby)
`ifdef IDEC_PERF_EN
    , .perf_issued(perf_issued), .perf_squashed(perf_squashed), .perf_stalled(perf_stalled)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  alu, rn, rd, rm;
    logic        cpsrs, reg_we, mem_we, ib, bl, sbr;
    logic [31:0] bv, brm;
    logic [1:0]  sc;
    logic [7:0]  sb;
  } dec_t;

  bit   m_valid;
  dec_t m_d;
  int   m_shadow, m_pend, m_iss, m_sq, m_st;
  bit   c_rdy, c_acc, c_hs, c_stall, c_drop;
  dec_t c_d;
  int   c_kind;
  logic last_rdy;

  // kind: 0 undecodable, 1 data-shift, 2 data-ror, 3 load/store, 4 branch
  function automatic void ref_decode(input logic [31:0] w, output dec_t d, output int kind);
    int cls, off;
    d    = '{default: '0};
    kind = 0;
    cls  = int'(w[27:25]);
    if (cls <= 1) begin
      kind = cls + 1;
      d.alu = w[24:21]; d.rn = w[19:16]; d.rd = w[15:12]; d.rm = w[3:0];
      d.cpsrs = w[20]; d.reg_we = 1'b1;
      if (cls == 1) begin
        d.sbr = 1'b1; d.sc = SC_ROR;
        d.sb  = 8'(w[11:8]) * 8'd2;
        d.brm = 32'(w[7:0]);
      end
    end else if (cls == 2 || cls == 3) begin
      kind = 3;
      d.rn = w[19:16]; d.rd = w[15:12];
      d.reg_we = w[20]; d.mem_we = !w[20];
    end else if (cls == 5) begin
      kind = 4;
      d.ib = 1'b1; d.bl = w[24];
      off = int'(w[23:0]);
      if (off >= 8388608) off = off - 16777216;
      d.bv = 32'(off * 4);
    end
  endfunction

  // Predicate pairs: even code tests, odd code is its negation.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (int'(c[3:1]))
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_eval();
    dec_t d; int k; bit pending, sop;
    ref_decode(instr_in, d, k);
    pending = (m_pend > 0) || (m_valid && m_d.cpsrs);
    sop     = (k == 1 || k == 2) && instr_in[20];
    c_stall = !flush && ((instr_in[31:28] != 4'hE && pending) || (sop && m_pend == MAXP));
    c_rdy   = (!m_valid || out_ready) && !c_stall && !flush;
    c_acc   = in_valid && c_rdy;
    c_hs    = m_valid && out_ready;
    c_drop  = (m_shadow > 0) || !cond_ok(instr_in[31:28], cpsr_in) || instr_in == 32'd0 || k == 0;
    c_d     = d;
    c_kind  = k;
  endtask

  task automatic model_commit();
    int p;
    p = m_pend + ((c_hs && m_d.cpsrs) ? 1 : 0) - ((flags_wb && m_pend > 0) ? 1 : 0);
    if (p > MAXP) p = MAXP;
    if (c_hs) m_iss++;
    if (c_acc && c_drop) m_sq++;
    if (in_valid && c_stall) m_st++;
    if (flush) begin
      m_valid = 1'b0; m_shadow = 0;
    end else if (c_acc) begin
      if (m_shadow > 0) m_shadow--;
      if (!c_drop) begin
        m_valid = 1'b1; m_d = c_d;
        if (c_kind == 4) m_shadow = BRS;
      end else begin
        m_valid = 1'b0;
      end
    end else if (c_hs) begin
      m_valid = 1'b0;
    end
    m_pend = p;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_d = '{default: '0};
    m_shadow = 0; m_pend = 0; m_iss = 0; m_sq = 0; m_st = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("alu", alu_out, m_d.alu);   chk("rn", rn_out, m_d.rn);
      chk("rd", rd_out, m_d.rd);      chk("rm", rm_out, m_d.rm);
      chk("cpsrs", cpsrs_out, m_d.cpsrs); chk("reg_we", reg_we, m_d.reg_we);
      chk("mem_we", mem_we, m_d.mem_we);  chk("ib", ib, m_d.ib);
      chk("bl", bl, m_d.bl);          chk("sbr", should_bypass_rm, m_d.sbr);
      chk("bv", bv, m_d.bv);          chk("bypass_rm", bypass_rm, m_d.brm);
      chk("shiftcode", shiftcode, m_d.sc); chk("shiftby", shiftby, m_d.sb);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 32'd0);
    chk({tag, "_bv"}, bv, 32'd0);
    chk({tag, "_ib"}, ib, 32'd0);
    chk({tag, "_alu"}, alu_out, 32'd0);
    chk({tag, "_rd"}, rd_out, 32'd0);
  endtask

  // One clock: inputs already applied just after a falling edge.
  task automatic tick();
    #1;
    model_eval();
    last_rdy = in_ready;
    chk("in_ready", in_ready, c_rdy);
    @(posedge clk);
    model_commit();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit ordy,
                       input logic [3:0] cp, input bit fwb, input bit fl);
    in_valid = v; instr_in = w; out_ready = ordy; cpsr_in = cp; flags_wb = fwb; flush = fl;
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r; logic [3:0] c; int sel;
    r   = $urandom;
    c   = ($urandom_range(0, 9) < 6) ? 4'hE : 4'($urandom_range(0, 15));
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: return {c, 3'b000, r[24:0]};
      3, 4:    return {c, 3'b001, r[24:0]};
      5, 6:    return {c, 2'b01, r[25:0]};
      7:       return {c, 3'b101, r[24:0]};
      8:       return {c, 3'b100, r[24:0]};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr_in = 32'd0; cpsr_in = 4'd0;
    flags_wb = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_zero("reset");
    chk("reset_in_ready", in_ready, 32'd1);
    rst = 1'b0;

    // MOV r1, #0xFF ROR 8
    drive(1, 32'hE3A014FF, 1, 4'd0, 0, 0);
    chk("ror_valid", out_valid, 32'd1); chk("ror_alu", alu_out, 32'hD);
    chk("ror_rd", rd_out, 32'd1);       chk("ror_sbr", should_bypass_rm, 32'd1);
    chk("ror_shiftby", shiftby, 32'd8); chk("ror_imm", bypass_rm, 32'hFF);
    drive(0, 32'd0, 1, 4'd0, 0, 0);

    // Branch then shadowed MOV
    drive(1, 32'hEAFFFFFE, 1, 4'd0, 0, 0);
    chk("br_ib", ib, 32'd1); chk("br_bv", bv, 32'hFFFFFFF8);
    drive(1, 32'hE3A01005, 1, 4'd0, 0, 0);
    chk("shadow_drop", out_valid, 32'd0);

    // Store then load
    drive(1, 32'hE5812000, 1, 4'd0, 0, 0);
    chk("str_mem_we", mem_we, 32'd1); chk("str_reg_we", reg_we, 32'd0);
    chk("str_rn", rn_out, 32'd1);     chk("str_rd", rd_out, 32'd2);
    drive(1, 32'hE5912000, 1, 4'd0, 0, 0);
    chk("ldr_reg_we", reg_we, 32'd1); chk("ldr_mem_we", mem_we, 32'd0);
    drive(0, 32'd0, 1, 4'd0, 0, 0);

    // ADDS then MOVEQ: stalled until the flag write-back
    drive(1, 32'hE2911001, 1, 4'b0100, 0, 0);
    drive(1, 32'h03A01000, 1, 4'b0100, 0, 0);
    chk("moveq_stall0", last_rdy, 32'd0);
    drive(1, 32'h03A01000, 1, 4'b0100, 0, 0);
    chk("moveq_stall1", last_rdy, 32'd0);
    drive(1, 32'h03A01000, 1, 4'b0100, 1, 0);
    chk("moveq_stall2", last_rdy, 32'd0);
    drive(1, 32'h03A01000, 1, 4'b0100, 0, 0);
    chk("moveq_go", last_rdy, 32'd1); chk("moveq_issue", out_valid, 32'd1);
    drive(1, 32'h03A01000, 1, 4'b0000, 0, 0);
    chk("moveq_fail_drop", out_valid, 32'd0);

    // BL held under backpressure, then flushed
    drive(1, 32'hEB000001, 1, 4'd0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 32'd0, 0, 4'd0, 0, 0);
      chk("hold_valid", out_valid, 32'd1); chk("hold_bv", bv, 32'd4); chk("hold_bl", bl, 32'd1);
    end
    drive(0, 32'd0, 0, 4'd0, 0, 1);
    chk("flush_valid", out_valid, 32'd0);

    // Two flag-setters out plus a branch shadow, then asynchronous reset
    drive(1, 32'hE2911001, 1, 4'd0, 0, 0);
    drive(1, 32'hE2911001, 1, 4'd0, 0, 0);
    drive(1, 32'hEAFFFFFE, 1, 4'd0, 0, 0);
    drive(0, 32'd0, 0, 4'd0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_zero("async_rst");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1, 32'hE2911001, 1, 4'd0, 0, 0);
    chk("post_rst_ready", last_rdy, 32'd1);
    chk("post_rst_issue", out_valid, 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 9) < 7,
            4'($urandom_range(0, 15)),
            (m_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
            $urandom_range(0, 24) == 0);
    end

`ifdef IDEC_PERF_EN
    chk("perf_issued", perf_issued, 32'(m_iss));
    chk("perf_squashed", perf_squashed, 32'(m_sq));
    chk("perf_stalled", perf_stalled, 32'(m_st));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
